// File: rtl/fir_coef_loader.sv
// rtl/fir_coef_loader.sv - 16-tap FIR coefficient loader with shadow/active banks
// A full, well-framed set is staged in the shadow bank and copied to the active bank in a single edge.
module fir_coef_loader #(
  parameter int NTAPS = 16,
  parameter int CW    = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [CW-1:0]         s_data,
  input  logic                  s_last,
  input  logic                  hold,
  output logic [NTAPS*CW-1:0]   coef_bus,
  output logic                  control,
  output logic                  upd,
  output logic                  err
);

  localparam int IW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NTAPS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t               state_q,   state_d;
  logic [IW-1:0]        idx_q,     idx_d;
  logic [CW-1:0]        shadow_q [NTAPS];
  logic [CW-1:0]        shadow_d [NTAPS];
  logic [NTAPS*CW-1:0]  coef_q,    coef_d;
  logic                 ready_q,   ready_d;
  logic                 control_q, control_d;
  logic                 upd_q,     upd_d;
  logic                 err_q,     err_d;
  logic                 beat;

  assign beat = s_valid & ready_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    coef_d    = coef_q;
    control_d = control_q;
    upd_d     = 1'b0;
    err_d     = err_q;

    case (state_q)
      ST_IDLE: begin
        if (beat) begin
          shadow_d[idx_q] = s_data;
          if (s_last) begin
            idx_d = '0;
            if (idx_q == LAST_IDX) begin
              state_d = ST_PEND;
            end else begin
              err_d = 1'b1;
            end
          end else if (idx_q == LAST_IDX) begin
            // Too many beats: flag now and swallow the rest of the frame.
            idx_d   = '0;
            err_d   = 1'b1;
            state_d = ST_DRAIN;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      ST_PEND: begin
        if (!hold) begin
          for (int k = 0; k < NTAPS; k++) begin
            coef_d[k*CW +: CW] = shadow_q[k];
          end
          control_d = 1'b1;
          upd_d     = 1'b1;
          idx_d     = '0;
          state_d   = ST_IDLE;
        end
      end

      ST_DRAIN: begin
        if (beat && s_last) begin
          idx_d   = '0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        idx_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    ready_d = (state_d != ST_PEND);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      for (int k = 0; k < NTAPS; k++) begin
        shadow_q[k] <= '0;
      end
      coef_q    <= '0;
      ready_q   <= 1'b0;
      control_q <= 1'b0;
      upd_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      coef_q    <= coef_d;
      ready_q   <= ready_d;
      control_q <= control_d;
      upd_q     <= upd_d;
      err_q     <= err_d;
    end
  end

  assign s_ready  = ready_q;
  assign coef_bus = coef_q;
  assign control  = control_q;
  assign upd      = upd_q;
  assign err      = err_q;

endmodule

// File: doc/fir_coef_loader.md
# fir_coef_loader

- Coefficient writer for the 16-tap FIR filter.
- Accepts a stream of signed 12-bit coefficients over a valid/ready handshake and assembles each complete set in a shadow bank.
- Commits a good set atomically to the active bank that drives the FIR coefficient inputs and `control`, so the filter never runs on a partially written set.

## Interface
Parameters:
- NTAPS, 16, number of coefficients per set
- CW, 12, coefficient width, two's complement

Ports:
- clk  in  1  rising-edge clock, single domain
- rst  in  1  reset, synchronous, active-high
- s_valid  in  1  coefficient beat valid
- s_ready  out  1  loader can accept a beat
- s_data  in  CW  coefficient, signed
- s_last  in  1  marks final beat of a set
- hold  in  1  while high, a complete set is not committed
- coef_bus  out  NTAPS*CW  active coefficients; coef k at [k*CW +: CW] (coef0 at [11:0]), wired to FIR coef0..coef15
- control  out  1  FIR enable; high once a valid set has been committed
- upd  out  1  one-cycle pulse on the cycle after a commit edge
- err  out  1  sticky framing-error flag

## Operation
- A beat transfers on a rising edge with s_valid=1 and s_ready=1. Beat i (0-based within a set) is written to shadow[i]. A 4-bit index counts beats.
- States:
  - IDLE/LOAD (s_ready=1): accepting beats.
  - PEND (s_ready=0): full shadow waiting to commit.
  - DRAIN (s_ready=1): discarding beats until s_last.
- IDLE/LOAD transitions:
  - Beat at idx=NTAPS-1 with s_last=1: go to PEND.
  - Beat with s_last=1 at idx<NTAPS-1 (short set): discard shadow, set err, idx←0, stay in IDLE.
  - Beat at idx=NTAPS-1 with s_last=0 (long set): discard, set err, go to DRAIN.
- DRAIN: accepts and drops beats. The beat with s_last=1 returns to IDLE with idx←0.
- PEND: on each edge, if hold=0, then coef_bus←shadow, control←1, upd←1, idx←0, go to IDLE. If hold=1, remain in PEND.
- The active bank changes only on a PEND commit edge, with all NTAPS words at once. Shadow contents are never visible on coef_bus.
- Coefficients pass unmodified: no sign extension, no saturation, bit-exact CW bits.
- err is cleared only by rst. It does not block later good sets.
- s_data and s_last are ignored when s_valid=0. s_valid is never required to stay asserted; s_ready does not depend on s_valid.

## Timing
- Reset edge (rst=1 sampled):
  - state←IDLE, idx←0, shadow←0.
  - coef_bus←0, control←0, upd←0, err←0.
  - s_ready=0 while rst=1; s_ready=1 the first cycle after rst is sampled low.
- rst has priority over every other event, including a beat or commit in the same cycle. Reset mid-load discards the partial set. Reset in PEND discards the pending set.
- Load throughput: one beat per cycle, NTAPS cycles per set when s_valid is held high.
- Commit latency: last beat accepted at edge N. PEND holds for the cycle N→N+1 with s_ready=0. With hold=0, coef_bus, control, and upd update at edge N+1, and s_ready=1 again from N+1. Minimum set period is NTAPS+1 cycles.
- Each extra cycle of hold=1 in PEND delays the commit by one edge. hold has no effect in IDLE, LOAD, or DRAIN.
- upd is high for exactly one cycle per commit. control never falls except on reset.
- A short set (s_last at idx<NTAPS-1) sets err on that beat's edge. A long set sets err on the beat at idx=NTAPS-1. In both cases coef_bus is unchanged.

## Test plan
- Reset release, then send 16 beats -99,65,136,33,-156,-86,376,854,854,376,-86,-156,33,136,65,-99 back-to-back with s_last on beat 15 and hold=0:
  - coef_bus[11:0]=12'hF9D, coef_bus[95:84]=12'h356, coef_bus[191:180]=12'hF9D.
  - control rises and upd pulses at the edge after beat 15.
  - s_ready is low for exactly one cycle.
- Same set with hold=1 for 5 cycles after the last beat: coef_bus stays 0 and s_ready stays 0 until hold falls; commit happens on the first edge with hold=0, and upd pulses once.
- Load set A, then send set B with s_last on beat 9: err=1; coef_bus still holds set A; the next full set C commits normally with err still 1.
- Send 20 beats with s_last only on beat 19: err=1 at beat 15; beats 16–19 are dropped; the following 16-beat set commits correctly.
- Random s_valid gaps (about 50% duty) while loading the set: coef_bus equals the set, with no beat lost or duplicated.
- Assert rst at beat 8 of a load after a prior committed set, then send a full set: coef_bus=0 and control=0 after reset; the new set then commits correctly with index restarted at 0.
